uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 158 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting one shared UART transmitter to NUM_REQ requesters.
// Optional frame timeout is enabled by defining UART_TX_ARB_TIMEOUT_EN.
//
// state       | meaning
// ST_IDLE     | no frame in flight, sampling i_req for the next winner
// ST_LAUNCH   | o_tx_signal pulse, byte and parity latched
// ST_WAIT_DONE| waiting for i_tx_done (or timeout when enabled)
// ST_ACK      | o_ack pulse to the granted requester, grant released
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int PARITY_ODD     = 0,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic [NUM_REQ-1:0]            o_ack,
  output logic                          o_tx_signal,
  output logic [DATA_WIDTH-1:0]         o_tx_data_byte,
  output logic                          o_tx_parity,
  input  logic                          i_tx_done,
  output logic                          o_busy,
  output logic                          o_timeout
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_ACK       = 2'd3;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 2");
  end

  logic [1:0]            state;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W-1:0]      cand_idx;
  logic [PTR_W-1:0]      next_ptr;
  logic                  win_found;
  logic [NUM_REQ-1:0]    win_onehot;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  win_parity;
  logic                  timeout_hit;
  int                    cand;

  // Scan from the pointer upward with wrap; first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!win_found && i_req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    win_data   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == PTR_W'(k)) begin
        win_onehot[k] = 1'b1;
        win_data      = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign win_parity = (^win_data) ^ (PARITY_ODD != 0);
  assign next_ptr   = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = (state == ST_WAIT_DONE) && !i_tx_done && (to_cnt == TO_LAST);

  // Counts whole cycles spent in WAIT_DONE; cleared whenever the frame leaves it.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      to_cnt    <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= timeout_hit;
      if (state == ST_WAIT_DONE && !i_tx_done && !timeout_hit) begin
        to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state          <= ST_IDLE;
      rr_ptr         <= '0;
      o_grant        <= '0;
      o_ack          <= '0;
      o_tx_signal    <= 1'b0;
      o_tx_data_byte <= '0;
      o_tx_parity    <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      o_tx_signal <= 1'b0;
      o_ack       <= '0;
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            o_grant        <= win_onehot;
            o_tx_data_byte <= win_data;
            o_tx_parity    <= win_parity;
            rr_ptr         <= next_ptr;
            o_tx_signal    <= 1'b1;
            o_busy         <= 1'b1;
            state          <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (i_tx_done || timeout_hit) begin
            o_ack <= o_grant;
            state <= ST_ACK;
          end
        end
        ST_ACK: begin
          o_grant <= '0;
          o_busy  <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          o_grant <= '0;
          o_busy  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: the driver queues expected launches and acks
// (cycle, grant, byte, parity); a negedge monitor pops and compares as the DUT presents them.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [3:0]  i_req;
  logic [31:0] i_req_data;
  logic        i_tx_done;

  logic [3:0]  o_grant, o_ack;
  logic        o_tx_signal, o_tx_parity, o_busy, o_timeout;
  logic [7:0]  o_tx_data_byte;

  logic [3:0]  odd_grant, odd_ack;
  logic        odd_tx_signal, odd_tx_parity, odd_busy, odd_timeout;
  logic [7:0]  odd_tx_data_byte;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .PARITY_ODD(0), .TIMEOUT_CYCLES(16)) u_dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_req(i_req), .i_req_data(i_req_data),
    .o_grant(o_grant), .o_ack(o_ack), .o_tx_signal(o_tx_signal),
    .o_tx_data_byte(o_tx_data_byte), .o_tx_parity(o_tx_parity), .i_tx_done(i_tx_done),
    .o_busy(o_busy), .o_timeout(o_timeout)
  );

  // Same stimulus, odd parity: only its parity output is compared.
  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .PARITY_ODD(1), .TIMEOUT_CYCLES(16)) u_dut_odd (
    .i_clock(i_clock), .i_reset(i_reset), .i_req(i_req), .i_req_data(i_req_data),
    .o_grant(odd_grant), .o_ack(odd_ack), .o_tx_signal(odd_tx_signal),
    .o_tx_data_byte(odd_tx_data_byte), .o_tx_parity(odd_tx_parity), .i_tx_done(i_tx_done),
    .o_busy(odd_busy), .o_timeout(odd_timeout)
  );

  always #5 i_clock = ~i_clock;

  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] grant;
    logic [7:0] data;
    logic       pe;
    logic       po;
  } launch_t;

  typedef struct {
    int         cyc;
    logic [3:0] ack;
    logic       tmo;
    logic [7:0] data;
  } ack_t;

  launch_t launch_q[$];
  ack_t    ack_q[$];
  int      checks = 0;
  int      errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge i_clock) begin
    if (o_tx_signal) begin
      if (launch_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_launch: got grant %0h expected no launch (cycle %0d)", o_grant, cyc);
      end else begin
        launch_t e;
        e = launch_q.pop_front();
        check("launch_cycle", cyc, e.cyc);
        check("launch_grant", o_grant, e.grant);
        check("launch_byte", o_tx_data_byte, e.data);
        check("parity_even", o_tx_parity, e.pe);
        check("parity_odd", odd_tx_parity, e.po);
      end
    end
    if (o_ack != 4'd0 || o_timeout) begin
      if (ack_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack %0h timeout %0b expected none (cycle %0d)", o_ack, o_timeout, cyc);
      end else begin
        ack_t a;
        a = ack_q.pop_front();
        check("ack_cycle", cyc, a.cyc);
        check("ack_vector", o_ack, a.ack);
        check("ack_timeout", o_timeout, a.tmo);
        check("byte_at_ack", o_tx_data_byte, a.data);
      end
    end
  end

  task automatic step();
    @(negedge i_clock);
  endtask

  task automatic set_data(input int k, input logic [7:0] b);
    i_req_data[k*8 +: 8] = b;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, o_grant, 0);
    check({tag, "_ack"}, o_ack, 0);
    check({tag, "_tx_signal"}, o_tx_signal, 0);
    check({tag, "_byte"}, o_tx_data_byte, 0);
    check({tag, "_parity"}, o_tx_parity, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_timeout"}, o_timeout, 0);
  endtask

  // Called at the negedge of an IDLE cycle with the request already driven.
  // mid: 0 nothing, 1 overwrite all data after grant, 2 drop i_req mid-frame.
  task automatic serve(input logic [3:0] g, input logic [7:0] b, input logic pe, input logic po,
                       input int wait_n, input int mid, input logic drop);
    launch_t l;
    ack_t    a;
    l.cyc = cyc + 1; l.grant = g; l.data = b; l.pe = pe; l.po = po;
    launch_q.push_back(l);
    step();
    check("busy_in_launch", o_busy, 1);
    if (mid == 1) i_req_data = '1;
    else if (mid == 2) i_req = '0;
    step();
    repeat (wait_n) step();
    a.cyc = cyc + 1; a.ack = g; a.tmo = 1'b0; a.data = b;
    ack_q.push_back(a);
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    if (drop) i_req = '0;
    step();
  endtask

  initial begin
    launch_t l;
    i_reset    = 1'b1;
    i_req      = '0;
    i_req_data = '0;
    i_tx_done  = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    i_reset = 1'b0;

    // Round-robin with all four held: 0,1,2,3,0, back to back
    i_req = 4'b1111;
    for (int k = 0; k < 4; k++) set_data(k, 8'(8'h10 + k));
    serve(4'b0001, 8'h10, 1'b1, 1'b0, 1, 0, 1'b0);
    serve(4'b0010, 8'h11, 1'b0, 1'b1, 0, 0, 1'b0);
    serve(4'b0100, 8'h12, 1'b0, 1'b1, 3, 0, 1'b0);
    serve(4'b1000, 8'h13, 1'b1, 1'b0, 1, 0, 1'b0);
    serve(4'b0001, 8'h10, 1'b1, 1'b0, 1, 0, 1'b1);
    check("idle_after_rr_busy", o_busy, 0);
    check("idle_after_rr_grant", o_grant, 0);
    repeat (3) step();

    // Stray done pulse while idle must not produce an ack
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    step();
    check("stray_done_busy", o_busy, 0);

    // Single request, 0xA5
    i_req = 4'b0001;
    set_data(0, 8'hA5);
    serve(4'b0001, 8'hA5, 1'b0, 1'b1, 2, 0, 1'b1);
    check("single_grant_cleared", o_grant, 0);

    // Data changes after grant do not disturb the frame
    set_data(2, 8'h3C);
    i_req = 4'b0100;
    serve(4'b0100, 8'h3C, 1'b0, 1'b1, 4, 1, 1'b1);

    // Parity bytes 0x07 and 0x03
    i_req_data = '0;
    set_data(3, 8'h07);
    i_req = 4'b1000;
    serve(4'b1000, 8'h07, 1'b1, 1'b0, 1, 0, 1'b1);
    set_data(1, 8'h03);
    i_req = 4'b0010;
    serve(4'b0010, 8'h03, 1'b0, 1'b1, 1, 0, 1'b1);

    // Request dropped mid-frame still completes and acks
    set_data(0, 8'h5A);
    i_req = 4'b0001;
    serve(4'b0001, 8'h5A, 1'b0, 1'b1, 2, 2, 1'b0);

    // Reset in WAIT_DONE: pointer is 1 so requester 1 wins first, then 0 after reset
    set_data(0, 8'h30);
    set_data(1, 8'h21);
    i_req = 4'b0011;
    l.cyc = cyc + 1; l.grant = 4'b0010; l.data = 8'h21; l.pe = 1'b0; l.po = 1'b1;
    launch_q.push_back(l);
    step();
    step();
    step();
    i_reset = 1'b1;
    step();
    check_all_zero("midreset");
    i_reset = 1'b0;
    serve(4'b0001, 8'h30, 1'b0, 1'b1, 1, 0, 1'b1);

`ifdef UART_TX_ARB_TIMEOUT_EN
    begin
      ack_t a;
      set_data(2, 8'h44);
      i_req = 4'b0100;
      l.cyc = cyc + 1; l.grant = 4'b0100; l.data = 8'h44; l.pe = 1'b0; l.po = 1'b1;
      launch_q.push_back(l);
      step();
      step();
      a.cyc = cyc + 16; a.ack = 4'b0100; a.tmo = 1'b1; a.data = 8'h44;
      ack_q.push_back(a);
      repeat (16) step();
      i_req = '0;
      step();
      check("timeout_idle_busy", o_busy, 0);
    end
`endif

    repeat (4) step();
    check("launch_queue_drained", launch_q.size(), 0);
    check("ack_queue_drained", ack_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
